// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control unit of the multi-cycle MIPS core.
// It contains a Moore FSM that sequences one instruction over 3-5 cycles.
// It drives the memory, IR, register-file, ALU and PC controls.
// The ALU decoder maps ALUOp/funct to alu_control.
// Optional build macro: CTRL_BNE_EN adds bne (op 000101) through BRANCH.
// STATE_W must be at least 4; bits above the 4-bit state encoding read as zero.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  // Supported opcodes
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  // R-type function codes understood by the ALU decoder
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  state_t     state_out;      // state seen by the output decode (FETCH while in reset)

  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       pc_write;
  logic       branch;
  logic       illegal_raw;
  logic       branch_taken;
  logic [1:0] alu_op;

  // State register; reset abandons whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; unused encodings 12-15 fall back to FETCH.
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
`ifdef CTRL_BNE_EN
          OP_BNE:       state_next = S_BRANCH;
`endif
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = S_MEMWB;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // While reset is held, all outputs show the FETCH values.
  assign state_out = reset ? S_FETCH : state_reg;

  // Moore output decode; every output defaults to 0.
  always_comb begin
    iord          = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    pc_write      = 1'b0;
    branch        = 1'b0;
    case (state_out)
      S_FETCH: begin
        alu_src_b    = 2'b01;
        ir_write_raw = 1'b1;
        pc_write     = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_MEMWR: begin
        iord          = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write_raw = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // DECODE falls back to FETCH only for an opcode it does not know.
  assign illegal_raw = (state_reg == S_DECODE) && (state_next == S_FETCH);

`ifdef CTRL_BNE_EN
  logic bne_reg;

  // Remember that the branch in flight is a bne; cleared on the way back to FETCH.
  always_ff @(posedge clk) begin
    if (reset || (state_next == S_FETCH)) begin
      bne_reg <= 1'b0;
    end else if (state_reg == S_DECODE) begin
      bne_reg <= (op == OP_BNE);
    end
  end

  assign branch_taken = branch & (zero ^ bne_reg);
`else
  assign branch_taken = branch & zero;
`endif

  // ALU decoder: ALUOp selects add/sub or defers to funct for R-type.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      2'b00: alu_control = ALU_ADD;
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // Write enables and the illegal pulse are suppressed while reset is held.
  assign mem_write  = mem_write_raw & ~reset;
  assign ir_write   = ir_write_raw  & ~reset;
  assign reg_write  = reg_write_raw & ~reset;
  assign pc_en      = (pc_write | branch_taken) & ~reset;
  assign illegal_op = illegal_raw & ~reset;
  assign state_dbg  = STATE_W'(state_out);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed + randomized bench for mips_multicycle_ctrl.
// The reference model tracks instruction class and cycle index within the instruction.
// It derives the expected state from per-class state sequences.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  // Instruction classes of the model
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_ILL = 6, C_BNE = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic       pc_en, illegal_op;
  logic [3:0] state_dbg;

  int total = 0;
  int bad   = 0;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src),
    .pc_en(pc_en), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       pc_write, branch;
  } row_t;

  row_t tbl [12];
  int len_tbl [8]    = '{5, 4, 4, 3, 4, 3, 2, 3};
  int seq_tbl [8][5] = '{'{0,1,2,3,4}, '{0,1,2,5,0}, '{0,1,6,7,0}, '{0,1,8,0,0},
                         '{0,1,9,10,0}, '{0,1,11,0,0}, '{0,1,0,0,0}, '{0,1,8,0,0}};
  int m_step = 0;
  int m_cls  = 0;

  initial begin
    for (int i = 0; i < 12; i++) tbl[i] = '0;
    tbl[0].alu_src_b = 2'b01; tbl[0].ir_write = 1'b1; tbl[0].pc_write = 1'b1;
    tbl[1].alu_src_b = 2'b11;
    tbl[2].alu_src_a = 1'b1;  tbl[2].alu_src_b = 2'b10;
    tbl[3].iord = 1'b1;
    tbl[4].mem_to_reg = 1'b1; tbl[4].reg_write = 1'b1;
    tbl[5].iord = 1'b1;       tbl[5].mem_write = 1'b1;
    tbl[6].alu_src_a = 1'b1;  tbl[6].alu_op = 2'b10;
    tbl[7].reg_dst = 1'b1;    tbl[7].reg_write = 1'b1;
    tbl[8].alu_src_a = 1'b1;  tbl[8].alu_op = 2'b01; tbl[8].pc_src = 2'b01; tbl[8].branch = 1'b1;
    tbl[9].alu_src_a = 1'b1;  tbl[9].alu_src_b = 2'b10;
    tbl[10].reg_write = 1'b1;
    tbl[11].pc_src = 2'b10;   tbl[11].pc_write = 1'b1;
  end

  function automatic int cls_of(input logic [5:0] o);
    case (o)
      OP_LW:    return C_LW;
      OP_SW:    return C_SW;
      OP_RTYPE: return C_R;
      OP_BEQ:   return C_BEQ;
      OP_ADDI:  return C_ADDI;
      OP_J:     return C_J;
`ifdef CTRL_BNE_EN
      OP_BNE:   return C_BNE;
`endif
      default:  return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [1:0] aop, input logic [5:0] f);
    if (aop == 2'b00) return 3'b010;
    if (aop == 2'b01) return 3'b110;
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Model advance: cycle index within the instruction, class fixed at the end of DECODE.
  always @(posedge clk) begin
    if (reset) begin
      m_step <= 0;
    end else if (m_step == 0) begin
      m_step <= 1;
    end else if (m_step == 1) begin
      m_cls  <= cls_of(op);
      m_step <= (len_tbl[cls_of(op)] > 2) ? 2 : 0;
    end else if (m_step + 1 >= len_tbl[m_cls]) begin
      m_step <= 0;
    end else begin
      m_step <= m_step + 1;
    end
  end

  // Compare every output against the model on every cycle.
  always @(negedge clk) begin
    int   code;
    row_t r;
    logic run;
    run  = ~reset;
    code = (m_step < 2) ? m_step : seq_tbl[m_cls][m_step];
    r    = run ? tbl[code] : tbl[0];
    chk("cmp_state",      state_dbg,   run ? code : 0);
    chk("cmp_iord",       iord,        r.iord);
    chk("cmp_mem_write",  mem_write,   r.mem_write & run);
    chk("cmp_ir_write",   ir_write,    r.ir_write & run);
    chk("cmp_reg_dst",    reg_dst,     r.reg_dst);
    chk("cmp_mem_to_reg", mem_to_reg,  r.mem_to_reg);
    chk("cmp_reg_write",  reg_write,   r.reg_write & run);
    chk("cmp_alu_src_a",  alu_src_a,   r.alu_src_a);
    chk("cmp_alu_src_b",  alu_src_b,   r.alu_src_b);
    chk("cmp_pc_src",     pc_src,      r.pc_src);
    chk("cmp_alu_ctrl",   alu_control, alu_of(r.alu_op, funct));
    chk("cmp_pc_en",      pc_en,
        run & (r.pc_write | (r.branch & (zero ^ (m_cls == C_BNE)))));
    chk("cmp_illegal",    illegal_op,  run & (m_step == 1) & (cls_of(op) == C_ILL));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z);
    @(posedge clk);
    #1;
    reset = r; op = o; funct = f; zero = z;
    @(negedge clk);
  endtask

  logic [5:0] op_pool [10];
  logic [5:0] fn_pool [6];

  initial begin
    int n_rw, n_iord, n_mw;
    op_pool = '{OP_LW, OP_SW, OP_RTYPE, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_BNE, OP_BAD, OP_RTYPE};
    fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    reset = 1'b1; op = OP_LW; funct = 6'd0; zero = 1'b0;

    // Reset held two cycles
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, OP_LW, 6'd0, 1'b0);
      chk("rst_state", state_dbg, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_ir_write", ir_write, 0);
      chk("rst_reg_write", reg_write, 0);
      chk("rst_pc_en", pc_en, 0);
    end

    // First fetch after release, then lw
    drive(1'b0, OP_LW, 6'd0, 1'b0);
    chk("fetch_ir_write", ir_write, 1);
    chk("fetch_pc_en", pc_en, 1);
    chk("fetch_alu_src_b", alu_src_b, 2'b01);
    chk("fetch_alu_control", alu_control, 3'b010);
    n_rw = int'(reg_write); n_iord = int'(iord);
    for (int s = 1; s <= 4; s++) begin
      drive(1'b0, OP_LW, 6'd0, 1'b0);
      chk("lw_state", state_dbg, s);
      n_rw += int'(reg_write); n_iord += int'(iord);
      if (s == 3) chk("lw_memrd_iord", iord, 1);
      if (s == 4) chk("lw_memwb_mem_to_reg", mem_to_reg, 1);
    end
    chk("lw_reg_write_cycles", n_rw, 1);
    chk("lw_iord_cycles", n_iord, 1);

    // sw
    drive(1'b0, OP_SW, 6'd0, 1'b0);
    chk("lw_len_back_to_fetch", state_dbg, 0);
    n_mw = int'(mem_write);
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, OP_SW, 6'd0, 1'b0);
      n_mw += int'(mem_write);
    end
    chk("sw_state", state_dbg, 5);
    chk("sw_iord", iord, 1);
    chk("sw_mem_write_cycles", n_mw, 1);

    // R-type slt
    drive(1'b0, OP_RTYPE, 6'b101010, 1'b0);
    chk("sw_len_back_to_fetch", state_dbg, 0);
    drive(1'b0, OP_RTYPE, 6'b101010, 1'b0);
    drive(1'b0, OP_RTYPE, 6'b101010, 1'b0);
    chk("slt_exec_state", state_dbg, 6);
    chk("slt_alu_control", alu_control, 3'b111);
    drive(1'b0, OP_RTYPE, 6'b101010, 1'b0);
    chk("slt_wb_reg_dst", reg_dst, 1);
    chk("slt_wb_reg_write", reg_write, 1);

    // beq taken then not taken
    for (int t = 1; t >= 0; t--) begin
      drive(1'b0, OP_BEQ, 6'd0, 1'b0);
      drive(1'b0, OP_BEQ, 6'd0, 1'b0);
      drive(1'b0, OP_BEQ, 6'd0, t[0]);
      chk("beq_state", state_dbg, 8);
      chk("beq_pc_en", pc_en, t);
      chk("beq_alu_control", alu_control, 3'b110);
      chk("beq_pc_src", pc_src, 2'b01);
    end

    // Illegal opcode
    drive(1'b0, OP_BAD, 6'd0, 1'b1);
    drive(1'b0, OP_BAD, 6'd0, 1'b1);
    chk("ill_pulse", illegal_op, 1);
    chk("ill_no_write", {mem_write, reg_write, pc_en, ir_write}, 0);
    drive(1'b0, OP_SW, 6'd0, 1'b0);
    chk("ill_back_to_fetch", state_dbg, 0);

    // Reset during MEMWR
    drive(1'b0, OP_SW, 6'd0, 1'b0);
    drive(1'b0, OP_SW, 6'd0, 1'b0);
    drive(1'b1, OP_SW, 6'd0, 1'b0);
    chk("midrst_mem_write", mem_write, 0);
    drive(1'b0, OP_BNE, 6'd0, 1'b0);
    chk("midrst_state", state_dbg, 0);

    // bne
    drive(1'b0, OP_BNE, 6'd0, 1'b0);
`ifdef CTRL_BNE_EN
    chk("bne_not_illegal", illegal_op, 0);
    drive(1'b0, OP_BNE, 6'd0, 1'b0);
    chk("bne_taken_pc_en", pc_en, 1);
    drive(1'b0, OP_BNE, 6'd0, 1'b1);
    drive(1'b0, OP_BNE, 6'd0, 1'b1);
    drive(1'b0, OP_BNE, 6'd0, 1'b1);
    chk("bne_not_taken_pc_en", pc_en, 0);
`else
    chk("bne_illegal", illegal_op, 1);
`endif

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (m_step == 0) begin
        op    = op_pool[$urandom_range(0, 9)];
        if (op == OP_BAD) op = 6'($urandom_range(0, 63));
        funct = fn_pool[$urandom_range(0, 5)];
        if (funct == 6'd0) funct = 6'($urandom_range(0, 63));
      end
      zero  = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 99) < 3);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control unit for the multi-cycle MIPS core instantiated under `top`.
- Sequences one instruction over 3–5 cycles through a Moore FSM.
- Drives every mux select and write enable of the shared datapath: memory, IR, register file, ALU and PC.
- Contains the ALU decoder, which maps ALUOp and funct to `alu_control`.

Parameters:
- STATE_W, 4, width of `state_dbg`; must be ≥ 4. Upper bits are zero.

Ports:
- clk  in  1  core clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- op  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  data memory write enable
- ir_write  out  1  IR load enable
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  register write data select: 0 = ALUOut, 1 = Data
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- alu_control  out  3  ALU operation code
- pc_src  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC register load enable
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- state_dbg  out  STATE_W  current state encoding

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12–15 transition to FETCH on the next edge.
- Reset: state becomes FETCH on the first rising edge with `reset`=1.
  - While `reset`=1, `mem_write`, `ir_write`, `reg_write`, `pc_en` and `illegal_op` are forced to 0 combinationally.
  - All other outputs follow FETCH values.
  - Reset asserted mid-instruction abandons the instruction; no partial write occurs after that edge.
- Transitions:
  - FETCH → DECODE.
  - DECODE, by op: 100011/101011 → MEMADR; 000000 → EXECUTE; 000100 → BRANCH; 001000 → ADDIEX; 000010 → JUMP; any other → FETCH, with `illegal_op`=1 for that cycle.
  - MEMADR: op 100011 → MEMRD, otherwise → MEMWR.
  - MEMRD → MEMWB; EXECUTE → ALUWB; ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- Outputs per state (unlisted outputs are 0; ALUOp is internal):
  - FETCH: alu_src_b=01, ALUOp=00, ir_write=1, pc_write=1.
  - DECODE: alu_src_b=11, ALUOp=00.
  - MEMADR: alu_src_a=1, alu_src_b=10, ALUOp=00.
  - MEMRD: iord=1.
  - MEMWB: mem_to_reg=1, reg_write=1.
  - MEMWR: iord=1, mem_write=1.
  - EXECUTE: alu_src_a=1, ALUOp=10.
  - ALUWB: reg_dst=1, reg_write=1.
  - BRANCH: alu_src_a=1, ALUOp=01, pc_src=01, branch=1.
  - ADDIEX: alu_src_a=1, alu_src_b=10, ALUOp=00.
  - ADDIWB: reg_write=1.
  - JUMP: pc_src=10, pc_write=1.
- pc_en = pc_write | (branch & zero). This is the only Mealy path, combinational from `zero`.
- ALU decoder:
  - ALUOp 00 → 010 (add); ALUOp 01 → 110 (sub).
  - ALUOp 10, by funct: 100000 → 010; 100010 → 110; 100100 → 000; 100101 → 001; 101010 → 111; other → 010.
  - An unsupported funct does not set `illegal_op`.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Optional Feature:
- Macro: CTRL_BNE_EN.
- Defined:
  - DECODE maps op 000101 to BRANCH with an internal `bne` flag latched at the DECODE → BRANCH edge.
  - In BRANCH, pc_en = pc_write | (branch & (zero ^ bne)).
  - The flag clears on return to FETCH and on reset.
- Undefined: op 000101 is illegal (→ FETCH, `illegal_op`=1).

Test Plan:
- Reset: hold `reset`=1 for 2 cycles with op=100011 → state_dbg=0, mem_write=ir_write=reg_write=pc_en=0. First cycle after release: ir_write=1, pc_en=1, alu_src_b=01, alu_control=010.
- lw: op=100011 → state_dbg sequence 0,1,2,3,4,0. Exactly one reg_write=1 cycle (MEMWB, mem_to_reg=1). iord=1 in MEMRD only. 5 cycles total.
- sw and R-type:
  - op=101011 → MEMWR with mem_write=1 and iord=1 for exactly one cycle.
  - op=000000, funct=101010 → EXECUTE with alu_control=111, then ALUWB with reg_dst=1 and reg_write=1.
- beq: op=000100 → pc_en=1 in BRANCH when zero=1, pc_en=0 when zero=0. alu_control=110, pc_src=01.
- Illegal opcode and mid-instruction reset:
  - op=111111 → illegal_op=1 in DECODE, next state FETCH, no writes.
  - `reset` asserted during MEMWR → mem_write=0 that cycle, state_dbg=0 next.
- CTRL_BNE_EN defined: op=000101 → pc_en=1 when zero=0, pc_en=0 when zero=1. Undefined: illegal_op=1.
